// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, modelled latency, valid/ready response out.
// Optional byte-strobed stores when DMEM_BYTE_STROBE_EN is defined (adds the req_wstrb port).
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [7:0]        req_wstrb,
`endif
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        cnt_r;
    logic              write_r;
    logic              err_r;
    logic [AW-1:0]     idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [7:0]        wstrb_r;
    logic [7:0]        wstrb_s;
    logic              req_ready_r;
    logic              busy_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              accept_s;
    logic              finish_s;
    logic              consume_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-lane merge of new store data over the old word.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [7:0]        strb);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Strobe source: explicit port when enabled, otherwise full-word stores.
`ifdef DMEM_BYTE_STROBE_EN
    assign wstrb_s = req_wstrb;
`else
    assign wstrb_s = 8'hFF;
`endif

    // Next-state and transaction event decode.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        finish_s  = 1'b0;
        consume_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    finish_s = 1'b1;
                    state_s  = ST_RESP;
                end else begin
                    state_s  = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    consume_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latch, latency counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            write_r      <= 1'b0;
            err_r        <= 1'b0;
            idx_r        <= '0;
            wdata_r      <= '0;
            wstrb_r      <= 8'h00;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            if (accept_s) begin
                write_r <= req_write;
                err_r   <= (req_addr >= 64'(DEPTH));
                idx_r   <= req_addr[AW-1:0];
                wdata_r <= req_wdata;
                wstrb_r <= wstrb_s;
                cnt_r   <= 4'(LATENCY - 1);
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (finish_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_r;
                resp_rdata_r <= (write_r || err_r) ? '0 : mem_r[idx_r];
            end else if (consume_s) begin
                resp_valid_r <= 1'b0;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= '0;
            end
        end
    end

    // Store commit; suppressed while reset is asserted so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (reset && finish_s && write_r && !err_r) begin
            mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, wstrb_r);
        end
    end

    assign req_ready  = req_ready_r;
    assign busy       = busy_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [63:0] resp_rdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [7:0]  req_wstrb;
    logic [7:0]  req_wstrb1;
`endif

    logic        req_valid1, req_write1, resp_ready1;
    logic [63:0] req_addr1, req_wdata1;
    logic        req_ready1, resp_valid1, resp_err1, busy1;
    logic [63:0] resp_rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .DATA_W(64), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_wstrb(req_wstrb),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH(256), .DATA_W(64), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
`ifdef DMEM_BYTE_STROBE_EN
        .req_wstrb(req_wstrb1),
`endif
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
        .resp_err(resp_err1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; hold = cycles to keep resp_ready low.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                          input int hold, output logic [63:0] rdata, output logic err,
                          output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 64'h0000_0000_0000_0011;
        req_wdata = 64'h5555_AAAA_5555_AAAA;
        check_eq("busy_in_wait", {63'd0, busy}, 64'd1);
        check_eq("ready_in_wait", {63'd0, req_ready}, 64'd0);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", {63'd0, resp_valid}, 64'd1);
            check_eq("hold_rdata", resp_rdata, rdata);
            check_eq("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    int          cyc;
    int          acc_q[$];
    int          last_acc;
    int          n_resp;

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 64'd0; req_wdata1 = 64'd0; resp_ready1 = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
        req_wstrb  = 8'hFF;
        req_wstrb1 = 8'hFF;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("rst_rdata", resp_rdata, 64'd0);
        check_eq("rst_err", {63'd0, resp_err}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;

        do_req(1'b1, 64'd5, 64'hDEAD_BEEF_0000_0001, 0, rd, er, lat);
        check_eq("st5_lat", 64'(lat), 64'd2);
        check_eq("st5_rdata", rd, 64'd0);
        check_eq("st5_err", {63'd0, er}, 64'd0);
        check_eq("idle_after_ack", {63'd0, req_ready}, 64'd1);

        do_req(1'b0, 64'd5, 64'd0, 0, rd, er, lat);
        check_eq("ld5_lat", 64'(lat), 64'd2);
        check_eq("ld5_rdata", rd, 64'hDEAD_BEEF_0000_0001);
        check_eq("ld5_err", {63'd0, er}, 64'd0);

        do_req(1'b0, 64'd256, 64'd0, 0, rd, er, lat);
        check_eq("ld256_err", {63'd0, er}, 64'd1);
        check_eq("ld256_rdata", rd, 64'd0);

        do_req(1'b0, 64'h1_0000_0005, 64'd0, 0, rd, er, lat);
        check_eq("ld_hi_err", {63'd0, er}, 64'd1);
        check_eq("ld_hi_rdata", rd, 64'd0);

        do_req(1'b1, 64'd44, 64'h0123_4567_89AB_CDEF, 0, rd, er, lat);
        do_req(1'b1, 64'd300, 64'hFFFF_0000_FFFF_0000, 0, rd, er, lat);
        check_eq("st300_err", {63'd0, er}, 64'd1);
        check_eq("st300_rdata", rd, 64'd0);
        do_req(1'b0, 64'd44, 64'd0, 0, rd, er, lat);
        check_eq("ld44_unchanged", rd, 64'h0123_4567_89AB_CDEF);

        do_req(1'b0, 64'd5, 64'd0, 5, rd, er, lat);
        check_eq("hold_ld5_rdata", rd, 64'hDEAD_BEEF_0000_0001);
        check_eq("post_hold_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("post_hold_ready", {63'd0, req_ready}, 64'd1);
        check_eq("post_hold_busy", {63'd0, busy}, 64'd0);

        do_req(1'b1, 64'd7, 64'h7777_0000_0000_7777, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd7; req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_eq("abort_ready", {63'd0, req_ready}, 64'd1);
        check_eq("abort_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        do_req(1'b0, 64'd7, 64'd0, 0, rd, er, lat);
        check_eq("ld7_old", rd, 64'h7777_0000_0000_7777);

`ifdef DMEM_BYTE_STROBE_EN
        req_wstrb = 8'hFF;
        do_req(1'b1, 64'd9, 64'd0, 0, rd, er, lat);
        req_wstrb = 8'h0F;
        do_req(1'b1, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat);
        req_wstrb = 8'h00;
        do_req(1'b1, 64'd9, 64'h1234_1234_1234_1234, 0, rd, er, lat);
        check_eq("strb0_ack_err", {63'd0, er}, 64'd0);
        req_wstrb = 8'hFF;
        do_req(1'b0, 64'd9, 64'd0, 0, rd, er, lat);
        check_eq("strb_ld9", rd, 64'h0000_0000_FFFF_FFFF);
`endif

        // LATENCY=1 instance: one store then back-to-back loads with valid/ready held high.
        @(negedge clk);
        cyc = 0;
        last_acc = -100;
        n_resp = 0;
        resp_ready1 = 1'b1;
        req_valid1  = 1'b1;
        req_write1  = 1'b1;
        req_addr1   = 64'd3;
        req_wdata1  = 64'hCAFE_F00D_0000_0003;
        for (int k = 0; k < 16; k++) begin
            if (req_ready1) begin
                acc_q.push_back(cyc + 1);
                last_acc = cyc + 1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_write1 = 1'b0;
                req_wdata1 = 64'd0;
            end
            if (resp_valid1) begin
                check_eq("l1_resp_lat", 64'(cyc - last_acc), 64'd1);
                check_eq("l1_resp_err", {63'd0, resp_err1}, 64'd0);
                check_eq("l1_resp_rdata", resp_rdata1, (n_resp == 0) ? 64'd0 : 64'hCAFE_F00D_0000_0003);
                n_resp++;
            end
        end
        req_valid1 = 1'b0;
        check_eq("l1_accepts_ge4", {63'd0, acc_q.size() >= 4}, 64'd1);
        check_eq("l1_resps_ge4", {63'd0, n_resp >= 4}, 64'd1);
        for (int i = 1; i < acc_q.size(); i++) begin
            check_eq("l1_spacing_ge2", {63'd0, (acc_q[i] - acc_q[i-1]) >= 2}, 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
